// File: rtl/mbist_fail_logger.sv
// mbist_fail_logger
//   Sits behind the MBIST 8-bit comparator. Each strobed compare (cmp_valid)
//   whose eq flag is low counts as a mismatch while the logger is ACTIVE.
//   For every mismatch it:
//   - bumps a saturating error counter;
//   - sets the sticky any_fail flag and captures the first failing address;
//   - pushes an (addr, expected, actual) record into a small FIFO.
//   The FIFO drains over a valid/ready port. A record that finds the FIFO full
//   (and no pop in the same cycle) is dropped and sets the sticky overflow flag.
//   Once test_done arrives the logger sits in DONE, where pass reports the
//   verdict.
//
// Optional build macro: MBIST_FAIL_STOP_EN
//   When defined, the first mismatch moves the FSM to DONE on the next cycle
//   and raises halt_req until the next start or reset. When undefined,
//   halt_req is tied low and logging runs until test_done.
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   start, test_done         control pulses from the MBIST controller
//   cmp_valid, eq            compare strobe and equal flag
//   addr, data_t, ramout     compared address, expected data, actual data
//   fail_valid, fail_ready   FIFO head handshake
//   fail_addr/exp/act        FIFO head record (zero while empty)
//   err_count                saturating mismatch count
//   first_fail_addr          address of the first mismatch
//   any_fail, overflow       sticky status flags
//   busy, done, pass         FSM status and final verdict
//   halt_req                 stop-on-fail request
module mbist_fail_logger #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              test_done,
  input  logic              cmp_valid,
  input  logic              eq,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_t,
  input  logic [DATA_W-1:0] ramout,
  output logic              fail_valid,
  input  logic              fail_ready,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_act,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic              any_fail,
  output logic              overflow,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              halt_req
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic [ADDR_W-1:0] first_fail_q, first_fail_d;
  logic              any_fail_q, any_fail_d;
  logic              overflow_q, overflow_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;

  // Record storage is datapath only; it is never reset because the
  // occupancy counter decides what is valid.
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] exp_mem_q  [DEPTH];
  logic [DATA_W-1:0] act_mem_q  [DEPTH];

  logic mismatch;
  logic push;
  logic pop;

  assign mismatch   = (state_q == S_ACTIVE) && cmp_valid && !eq && !start;
  assign fail_valid = (count_q != '0);
  assign pop        = fail_valid && fail_ready;
  // A full FIFO still takes the record when its head leaves in the same cycle.
  assign push       = mismatch && ((count_q < DEPTH_C) || pop);

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (start)          state_d = S_ACTIVE;
        else if (test_done) state_d = S_DONE;
`ifdef MBIST_FAIL_STOP_EN
        else if (mismatch)  state_d = S_DONE;
`endif
      end
      S_DONE: begin
        if (start) state_d = S_ACTIVE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counters, sticky flags and FIFO pointers
  always_comb begin
    err_count_d  = err_count_q;
    first_fail_d = first_fail_q;
    any_fail_d   = any_fail_q;
    overflow_d   = overflow_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    if (start) begin
      err_count_d  = '0;
      first_fail_d = '0;
      any_fail_d   = 1'b0;
      overflow_d   = 1'b0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
    end else begin
      if (mismatch) begin
        if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
        any_fail_d = 1'b1;
        if (!any_fail_q) first_fail_d = addr;
        if (!push) overflow_d = 1'b1;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      err_count_q  <= '0;
      first_fail_q <= '0;
      any_fail_q   <= 1'b0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      err_count_q  <= err_count_d;
      first_fail_q <= first_fail_d;
      any_fail_q   <= any_fail_d;
      overflow_q   <= overflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= addr;
      exp_mem_q[wr_ptr_q]  <= data_t;
      act_mem_q[wr_ptr_q]  <= ramout;
    end
  end

`ifdef MBIST_FAIL_STOP_EN
  logic halt_q, halt_d;

  always_comb begin
    halt_d = halt_q;
    if (start)         halt_d = 1'b0;
    else if (mismatch) halt_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) halt_q <= 1'b0;
    else        halt_q <= halt_d;
  end

  assign halt_req = halt_q;
`else
  assign halt_req = 1'b0;
`endif

  // Head fields are masked while empty so stale storage never leaks out.
  assign fail_addr       = fail_valid ? addr_mem_q[rd_ptr_q] : '0;
  assign fail_exp        = fail_valid ? exp_mem_q[rd_ptr_q]  : '0;
  assign fail_act        = fail_valid ? act_mem_q[rd_ptr_q]  : '0;
  assign err_count       = err_count_q;
  assign first_fail_addr = first_fail_q;
  assign any_fail        = any_fail_q;
  assign overflow        = overflow_q;
  assign busy            = (state_q == S_ACTIVE);
  assign done            = (state_q == S_DONE);
  assign pass            = (state_q == S_DONE) && !any_fail_q;

endmodule

// File: tb/tb_mbist_fail_logger.sv
module tb_mbist_fail_logger;

  logic       clk = 1'b0;
  logic       rst_n, start, test_done, cmp_valid, eq, fail_ready;
  logic [7:0] addr, data_t, ramout;

  logic       fail_valid, any_fail, overflow, busy, done, pass, halt_req;
  logic [7:0] fail_addr, fail_exp, fail_act, err_count, first_fail_addr;

  logic       fail_valid_s, any_fail_s, overflow_s, busy_s, done_s, pass_s, halt_req_s;
  logic [7:0] fail_addr_s, fail_exp_s, fail_act_s, first_fail_addr_s;
  logic [1:0] err_count_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mbist_fail_logger #(.ADDR_W(8), .DATA_W(8), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .test_done(test_done),
    .cmp_valid(cmp_valid), .eq(eq), .addr(addr), .data_t(data_t), .ramout(ramout),
    .fail_valid(fail_valid), .fail_ready(fail_ready), .fail_addr(fail_addr),
    .fail_exp(fail_exp), .fail_act(fail_act), .err_count(err_count),
    .first_fail_addr(first_fail_addr), .any_fail(any_fail), .overflow(overflow),
    .busy(busy), .done(done), .pass(pass), .halt_req(halt_req)
  );

  // Second instance with a 2-bit counter for saturation checks.
  mbist_fail_logger #(.ADDR_W(8), .DATA_W(8), .DEPTH(4), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .test_done(test_done),
    .cmp_valid(cmp_valid), .eq(eq), .addr(addr), .data_t(data_t), .ramout(ramout),
    .fail_valid(fail_valid_s), .fail_ready(fail_ready), .fail_addr(fail_addr_s),
    .fail_exp(fail_exp_s), .fail_act(fail_act_s), .err_count(err_count_s),
    .first_fail_addr(first_fail_addr_s), .any_fail(any_fail_s), .overflow(overflow_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .halt_req(halt_req_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic mis(input logic [7:0] a, input logic [7:0] e, input logic [7:0] act);
    cmp_valid = 1'b1; eq = 1'b0; addr = a; data_t = e; ramout = act;
    cyc();
    cmp_valid = 1'b0; eq = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; test_done = 1'b0; cmp_valid = 1'b0; eq = 1'b1;
    fail_ready = 1'b0; addr = '0; data_t = '0; ramout = '0;
    cyc(); cyc();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fvalid", fail_valid, 0);
    chk("rst_err", err_count, 0);
    chk("rst_halt", halt_req, 0);
    rst_n = 1'b1;

    // 1: clean run
    do_start();
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 16; i++) begin
      cmp_valid = 1'b1; eq = 1'b1; addr = 8'(i); data_t = 8'hA5; ramout = 8'hA5;
      cyc();
    end
    cmp_valid = 1'b0;
    test_done = 1'b1; cyc(); test_done = 1'b0;
    chk("t1_done", done, 1);
    chk("t1_pass", pass, 1);
    chk("t1_err", err_count, 0);
    chk("t1_fvalid", fail_valid, 0);

    // 2: single mismatch, one-cycle latency
    do_start();
    chk("t2_busy", busy, 1);
    mis(8'h12, 8'h55, 8'h54);
    chk("t2_fvalid", fail_valid, 1);
    chk("t2_faddr", fail_addr, 8'h12);
    chk("t2_fexp", fail_exp, 8'h55);
    chk("t2_fact", fail_act, 8'h54);
    chk("t2_first", first_fail_addr, 8'h12);
    chk("t2_err", err_count, 1);
    chk("t2_anyfail", any_fail, 1);
    cyc();
    chk("t2_hold", fail_addr, 8'h12);

    // mismatch coincident with start is ignored; with test_done it is logged
    start = 1'b1; cmp_valid = 1'b1; eq = 1'b0; addr = 8'h33;
    cyc();
    start = 1'b0; cmp_valid = 1'b0; eq = 1'b1;
    chk("st_err", err_count, 0);
    chk("st_fvalid", fail_valid, 0);
    chk("st_anyfail", any_fail, 0);
    test_done = 1'b1; cmp_valid = 1'b1; eq = 1'b0; addr = 8'h34;
    cyc();
    test_done = 1'b0; cmp_valid = 1'b0; eq = 1'b1;
    chk("td_done", done, 1);
    chk("td_err", err_count, 1);
    chk("td_faddr", fail_addr, 8'h34);
    chk("td_pass", pass, 0);

`ifdef MBIST_FAIL_STOP_EN
    // 6: stop on first fail
    do_start();
    chk("t6_halt_clr", halt_req, 0);
    mis(8'h07, 8'h01, 8'h00);
    chk("t6_done", done, 1);
    chk("t6_halt", halt_req, 1);
    chk("t6_err", err_count, 1);
    mis(8'h08, 8'h01, 8'h00);
    mis(8'h09, 8'h01, 8'h00);
    chk("t6_err_hold", err_count, 1);
    chk("t6_faddr", fail_addr, 8'h07);
    do_start();
    chk("t6_halt_start", halt_req, 0);
    chk("t6_busy", busy, 1);
    mis(8'h0A, 8'h01, 8'h00);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_halt", halt_req, 0);
    chk("t6_rst_err", err_count, 0);
    chk("t6_rst_fvalid", fail_valid, 0);
    chk("t6_rst_anyfail", any_fail, 0);
`else
    // 3: overflow with six mismatches
    do_start();
    fail_ready = 1'b0;
    for (int i = 0; i < 6; i++) mis(8'(i), 8'hF0, 8'(i));
    chk("t3_err", err_count, 6);
    chk("t3_ovf", overflow, 1);
    chk("t3_first", first_fail_addr, 0);
    chk("t3_halt", halt_req, 0);
    chk("t3_busy", busy, 1);
    fail_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_dvalid", fail_valid, 1);
      chk("t3_daddr", fail_addr, 32'(i));
      chk("t3_dact", fail_act, 32'(i));
      cyc();
    end
    chk("t3_empty", fail_valid, 0);
    fail_ready = 1'b0;

    // 4: push into a full FIFO while the head pops
    do_start();
    for (int i = 0; i < 4; i++) mis(8'h10 + 8'(i), 8'hAA, 8'hAB);
    chk("t4_full_ovf", overflow, 0);
    fail_ready = 1'b1;
    mis(8'h20, 8'hCC, 8'hCD);
    fail_ready = 1'b0;
    chk("t4_ovf", overflow, 0);
    chk("t4_head", fail_addr, 8'h11);
    mis(8'h30, 8'h00, 8'h01);
    chk("t4_full", overflow, 1);
    fail_ready = 1'b1;
    chk("t4_d0", fail_addr, 8'h11); cyc();
    chk("t4_d1", fail_addr, 8'h12); cyc();
    chk("t4_d2", fail_addr, 8'h13); cyc();
    chk("t4_d3", fail_addr, 8'h20);
    chk("t4_d3exp", fail_exp, 8'hCC); cyc();
    chk("t4_empty", fail_valid, 0);
    fail_ready = 1'b0;

    // 5: saturation, verdict, clear
    do_start();
    for (int i = 0; i < 5; i++) mis(8'h40 + 8'(i), 8'h11, 8'h10);
    chk("t5_err_sat", err_count_s, 3);
    chk("t5_err_main", err_count, 5);
    test_done = 1'b1; cyc(); test_done = 1'b0;
    chk("t5_done", done_s, 1);
    chk("t5_pass", pass_s, 0);
    chk("t5_ovf", overflow_s, 1);
    mis(8'h50, 8'h11, 8'h10);
    chk("t5_done_ign", err_count, 5);
    do_start();
    chk("t5_clr_err", err_count_s, 0);
    chk("t5_clr_any", any_fail_s, 0);
    chk("t5_clr_ovf", overflow_s, 0);
    chk("t5_clr_fv", fail_valid_s, 0);
    chk("t5_clr_first", first_fail_addr, 0);

    // no stop-on-fail: logging continues, reset mid-ACTIVE clears all
    mis(8'h07, 8'h01, 8'h00);
    mis(8'h08, 8'h01, 8'h00);
    chk("ns_halt", halt_req, 0);
    chk("ns_busy", busy, 1);
    chk("ns_err", err_count, 2);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk("ns_rst_busy", busy, 0);
    chk("ns_rst_err", err_count, 0);
    chk("ns_rst_fvalid", fail_valid, 0);
    chk("ns_rst_faddr", fail_addr, 0);
    chk("ns_rst_anyfail", any_fail, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
